bcd2bin_seq: RTL
================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; inverse of the combinational bin2bcd path.
//  Accepts a packed DIGITS-digit BCD word and returns its binary value.
//  Uses reverse double-dabble: one shift-right step per clock.
//  Valid/ready on both sides; sits between BCD front-ends (keypad/display regs) and binary datapaths.
// PARAMETERS
//  DIGITS  3   number of BCD digits in the input word
//  BIN_W   10  output width; must satisfy 2^BIN_W > 10^DIGITS-1; also the shift-step count
// PORTS
//  clk        in   1          single clock, all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          in_bcd valid
//  in_ready   out  1          block can accept a word
//  in_bcd     in   4*DIGITS   packed BCD; digit 0 = [3:0] (units)
//  out_valid  out  1          out_bin/out_err valid
//  out_ready  in   1          consumer accepts result
//  out_bin    out  BIN_W      binary result
//  out_err    out  1          invalid digit seen (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; in_ready=1, out_valid=0, out_bin=0, out_err=0; sticky internal regs cleared.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready at edge k:
//    - load shift reg {bcd=in_bcd, bin=0}; cnt=0; go SHIFT.
//  - SHIFT: in_ready=0. Each edge:
//    - shift {bcd,bin} right 1 (bcd LSB -> bin MSB);
//    - then every digit of new bcd field >= 8 gets -3; cnt++.
//    - After BIN_W steps (edge k+BIN_W) go DONE.
//  - DONE: out_valid=1; out_bin = bin field, held stable until out_ready=1.
//    - Edge with out_ready=1: out_valid=0, go IDLE.
//    - in_ready stays 0 in DONE; next accept no earlier than the following cycle.
//  - Latency: out_valid rises at edge k+BIN_W (k = accept edge).
//    Max throughput: 1 word per BIN_W+2 cycles.
//  - in_valid/in_bcd are ignored while in_ready=0; no queuing.
//  - out_bin arithmetic is unsigned and exact for all valid BCD inputs 0..10^DIGITS-1.
//    No overflow is possible given the BIN_W constraint.
//  - rst mid-SHIFT or mid-DONE: conversion discarded, IDLE next cycle, out_valid=0 immediately after the reset edge.
//  - rst has priority over any simultaneous handshake.
// CONFIGURATION
//  Macro BCD2BIN_DIGIT_CHECK_EN:
//  - Defined:
//    - at accept, any nibble of in_bcd > 9 sets a sticky error flag;
//    - in DONE, out_err=1 and out_bin forced to 0;
//    - latency and handshake unchanged.
//  - Undefined:
//    - no checking logic; out_err tied 0;
//    - out_bin for non-BCD input is whatever the algorithm yields (unspecified).
// TESTING
//  1. in_bcd=12'h000 -> out_bin=0, out_err=0; out_valid exactly BIN_W (10) cycles after accept.
//  2. in_bcd=12'h999 -> out_bin=999; in_bcd=12'h255 -> 255; in_bcd=12'h100 -> 100.
//  3. Exhaustive 0..999 via Verilog %/ reference model, out_ready=1 always -> 0 mismatches; print "Test pass!".
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_bin stable;
//     in_ready=0 throughout, and in_valid pulses during this window are not accepted.
//  5. rst=1 at cnt=4 of SHIFT -> next cycle IDLE, in_ready=1, out_valid=0.
//     A new word 12'h042 then yields 42.
//  6. Macro defined, in_bcd=12'h1A5 -> out_err=1, out_bin=0.
//     Macro undefined -> out_err=0 for every input.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift step per clock.
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      out_bin,
   output logic                  out_err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Undo the doubling correction: any digit that received a carried-in weight of 8 loses 3.
   function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd8) begin
            res[4*d +: 4] = bcd[4*d +: 4] - 4'd3;
         end else begin
            res[4*d +: 4] = bcd[4*d +: 4];
         end
      end
      return res;
   endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
   function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd[4*d +: 4] > 4'd9) begin
            bad = 1'b1;
         end else begin
            bad = bad;
         end
      end
      return bad;
   endfunction
`endif

   state_t              r_state;
   logic [SR_W-1:0]     r_sr;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [BIN_W-1:0]    r_out_bin;
   logic [SR_W-1:0]     w_shifted;
   logic [SR_W-1:0]     w_step;

   // One algorithm step: shift {bcd,bin} right, then correct the bcd digits.
   always_comb begin
      w_shifted = r_sr >> 1;
      w_step    = {adjust_digits(w_shifted[SR_W-1:BIN_W]), w_shifted[BIN_W-1:0]};
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic r_err;
   logic r_out_err;
   assign out_err = r_out_err;
`else
   assign out_err = 1'b0;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_bin   = r_out_bin;

   // Control FSM and datapath registers; reset takes priority over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_bin   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
         r_err       <= 1'b0;
         r_out_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sr       <= {in_bcd, {BIN_W{1'b0}}};
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SHIFT;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  r_err      <= has_bad_digit(in_bcd);
`endif
               end
            end
            S_SHIFT: begin
               r_sr  <= w_step;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  if (r_err) begin
                     r_out_bin <= '0;
                     r_out_err <= 1'b1;
                  end else begin
                     r_out_bin <= w_step[BIN_W-1:0];
                     r_out_err <= 1'b0;
                  end
`else
                  r_out_bin   <= w_step[BIN_W-1:0];
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                  r_out_err   <= 1'b0;
`endif
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
